// File: rtl/calc_sequencer.sv
`default_nettype none
// calc_sequencer: multi-cycle add/sub/mul/div/mod engine with a 6-digit display range check.
// Optional macro CALC_MOD_EN enables MOD (op 5); without it op 5 is rejected as illegal.
module calc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               MAX_POS     = 999999,
  parameter int               MAX_NEG_MAG = 99999,
  parameter logic [WIDTH-1:0] ERR_CODE    = 32'h00EE_0000
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic             cal_enable,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       operator,
  output logic [WIDTH-1:0] ans,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_EQU   = 3'd0;
  localparam logic [2:0] OP_TIMES = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_PLUS  = 3'd3;
  localparam logic [2:0] OP_MINUS = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;

  localparam logic signed [WIDTH:0] LIM_POS = (WIDTH + 1)'(MAX_POS);
  localparam logic signed [WIDTH:0] LIM_NEG = -((WIDTH + 1)'(MAX_NEG_MAG));

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       a_q, b_q, a_mag_q, b_mag_q, quo_q, ans_q;
  logic [2:0]             op_q;
  logic                   sign_a_q, sign_b_q, flag_q;
  logic [CW-1:0]          cnt_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic signed [WIDTH:0]  r_q;
  logic                   busy_q, done_q, err_q;

  // acc_q holds the running product for TIMES and the partial remainder for DIV/MOD.
  logic [2*WIDTH-1:0] mul_d;
  logic [WIDTH:0]     rem_shift_d, rem_d;
  logic               qbit_d;

  always_comb begin
    mul_d = {acc_q[2*WIDTH-2:0], 1'b0};
    if (b_mag_q[cnt_q]) begin
      mul_d = mul_d + {{WIDTH{1'b0}}, a_mag_q};
    end
    rem_shift_d = {acc_q[WIDTH-1:0], a_mag_q[cnt_q]};
    qbit_d      = (rem_shift_d >= {1'b0, b_mag_q});
    rem_d       = qbit_d ? (rem_shift_d - {1'b0, b_mag_q}) : rem_shift_d;
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      quo_q    <= '0;
      ans_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cal_enable) begin
            a_q     <= operand1;
            b_q     <= operand2;
            op_q    <= operator;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end

        S_PREP: begin
          acc_q    <= '0;
          quo_q    <= '0;
          cnt_q    <= C_LAST;
          flag_q   <= 1'b0;
          r_q      <= '0;
          sign_a_q <= a_q[WIDTH-1];
          sign_b_q <= b_q[WIDTH-1];
          a_mag_q  <= a_q[WIDTH-1] ? -a_q : a_q;
          b_mag_q  <= b_q[WIDTH-1] ? -b_q : b_q;
          state_q  <= S_CHECK;
          case (op_q)
            OP_EQU:   r_q <= {a_q[WIDTH-1], a_q};
            OP_PLUS:  r_q <= {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
            OP_MINUS: r_q <= {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
            OP_TIMES: state_q <= S_ITER;
            OP_DIV: begin
              if (b_q == '0) flag_q <= 1'b1;
              else           state_q <= S_ITER;
            end
`ifdef CALC_MOD_EN
            OP_MOD: begin
              if (b_q == '0) flag_q <= 1'b1;
              else           state_q <= S_ITER;
            end
`endif
            default: flag_q <= 1'b1;
          endcase
        end

        S_ITER: begin
          if (op_q == OP_TIMES) begin
            acc_q <= mul_d;
          end else begin
            acc_q        <= {{(WIDTH-1){1'b0}}, rem_d};
            quo_q[cnt_q] <= qbit_d;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_FIX;
        end

        S_FIX: begin
          state_q <= S_CHECK;
          case (op_q)
            OP_TIMES: begin
              flag_q <= |acc_q[2*WIDTH-1:WIDTH-1];
              r_q    <= (sign_a_q ^ sign_b_q) ? -{1'b0, acc_q[WIDTH-1:0]}
                                              :  {1'b0, acc_q[WIDTH-1:0]};
            end
            OP_DIV: begin
              r_q <= (sign_a_q ^ sign_b_q) ? -{1'b0, quo_q} : {1'b0, quo_q};
            end
`ifdef CALC_MOD_EN
            // Remainder follows the dividend's sign.
            OP_MOD: begin
              r_q <= sign_a_q ? -{1'b0, acc_q[WIDTH-1:0]} : {1'b0, acc_q[WIDTH-1:0]};
            end
`endif
            default: flag_q <= 1'b1;
          endcase
        end

        S_CHECK: begin
          if (flag_q || (r_q > LIM_POS) || (r_q < LIM_NEG)) begin
            ans_q <= ERR_CODE;
            err_q <= 1'b1;
          end else begin
            ans_q <= r_q[WIDTH-1:0];
            err_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ans  = ans_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// Scoreboard bench for calc_sequencer: randomized and directed operations against an arithmetic model.
module tb_calc_sequencer;

`ifdef CALC_MOD_EN
  localparam bit MOD_EN = 1'b1;
`else
  localparam bit MOD_EN = 1'b0;
`endif
  localparam logic [31:0] ERRC  = 32'h00EE_0000;
  localparam longint      TWO31 = 64'sd2147483648;

  logic        sw_clk = 1'b0;
  logic        rst = 1'b0;
  logic        cal_enable = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [2:0]  operator = '0;
  logic [31:0] ans;
  logic        busy, done, err;

  calc_sequencer dut (
    .sw_clk    (sw_clk),
    .rst       (rst),
    .cal_enable(cal_enable),
    .operand1  (operand1),
    .operand2  (operand2),
    .operator  (operator),
    .ans       (ans),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 sw_clk = ~sw_clk;

  int unsigned cyc = 0;
  always @(posedge sw_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] ans;
    logic        err;
    int unsigned at;
  } exp_t;

  exp_t scb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: signed arithmetic on 64-bit integers, then the display range rule.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int unsigned e);
    exp_t   x;
    longint sa, sbv, r;
    bit     isbad;
    int     lat;
    sa    = longint'($signed(a));
    sbv   = longint'($signed(b));
    r     = 0;
    isbad = 1'b0;
    lat   = 2;
    case (op)
      3'd0: r = sa;
      3'd3: r = sa + sbv;
      3'd4: r = sa - sbv;
      3'd1: begin
        lat = 35;
        r   = sa * sbv;
        if (r >= TWO31 || r <= -TWO31) isbad = 1'b1;
      end
      3'd2: begin
        if (sbv == 0) isbad = 1'b1;
        else begin lat = 35; r = sa / sbv; end
      end
      3'd5: begin
        if (!MOD_EN || sbv == 0) isbad = 1'b1;
        else begin lat = 35; r = sa % sbv; end
      end
      default: isbad = 1'b1;
    endcase
    if (r > 999999 || r < -99999) isbad = 1'b1;
    x.ans = isbad ? ERRC : r[31:0];
    x.err = isbad;
    x.at  = e + lat;
    return x;
  endfunction

  always @(negedge sw_clk) begin
    if (rst && done) begin
      if (scb.size() == 0) begin
        chk("unexpected_done", 64'(ans), 64'(ERRC ^ ans ^ 32'h1));
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk("ans", 64'(ans), 64'(e.ans));
        chk("err", 64'(err), 64'(e.err));
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    operator   = op;
    operand1   = a;
    operand2   = b;
    cal_enable = 1'b1;
    @(posedge sw_clk);
    #1;
    scb.push_back(model(op, a, b, cyc));
    @(negedge sw_clk);
    cal_enable = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (scb.size() != 0 && n < budget) begin
      @(negedge sw_clk);
      n++;
    end
    if (scb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout pending=%0d required=0", scb.size());
      scb.delete();
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 2000)) - 32'd1000;
      1: return 32'($urandom_range(0, 4000000)) - 32'd2000000;
      2: return $urandom;
      default: begin
        case ($urandom_range(0, 8))
          0: return 32'd0;
          1: return 32'd1;
          2: return 32'hFFFF_FFFF;
          3: return 32'd999999;
          4: return -32'd99999;
          5: return 32'd1000000;
          6: return -32'd100000;
          7: return 32'h8000_0000;
          default: return 32'h7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sw_clk);
    chk("rst_ans", 64'(ans), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    @(negedge sw_clk);

    start_op(3'd3, 32'd123, 32'd456);
    chk("plus_busy_e0", 64'(busy), 64'd1);
    @(negedge sw_clk);
    chk("plus_busy_e1", 64'(busy), 64'd1);
    @(negedge sw_clk);
    chk("plus_busy_e2", 64'(busy), 64'd0);
    wait_done(40);
    chk("plus_ans", 64'(ans), 64'd579);

    start_op(3'd1, -32'd5, 32'd20000);
    wait_done(40);
    chk("times_ovf_ans", 64'(ans), 64'(ERRC));
    start_op(3'd1, 32'd999, 32'd1000);
    wait_done(40);
    chk("times_ans", 64'(ans), 64'd999000);

    start_op(3'd2, 32'd7, 32'd0);
    wait_done(40);
    chk("div0_err", 64'(err), 64'd1);
    start_op(3'd2, -32'd17, 32'd5);
    wait_done(40);
    chk("div_ans", 64'(ans), 64'hFFFF_FFFD);

    start_op(3'd5, -32'd17, 32'd5);
    wait_done(40);
    start_op(3'd7, 32'd3, 32'd4);
    wait_done(40);
    chk("op7_ans", 64'(ans), 64'(ERRC));
    start_op(3'd0, -32'd42, 32'd9);
    wait_done(40);

    // A strobe while busy must be dropped; a strobe during done must be taken.
    start_op(3'd1, 32'd12, 32'd12);
    repeat (9) @(negedge sw_clk);
    operator   = 3'd3;
    operand1   = 32'd1;
    operand2   = 32'd1;
    cal_enable = 1'b1;
    @(posedge sw_clk);
    @(negedge sw_clk);
    cal_enable = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge sw_clk);
    chk("ignored_ans", 64'(ans), 64'd144);
    start_op(3'd3, 32'd40, 32'd2);
    wait_done(40);
    chk("done_cycle_accept_ans", 64'(ans), 64'd42);

    start_op(3'd1, 32'd999, 32'd999);
    repeat (14) @(negedge sw_clk);
    rst = 1'b0;
    #1;
    chk("midrst_ans", 64'(ans), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    scb.delete();
    @(negedge sw_clk);
    rst = 1'b1;
    @(negedge sw_clk);
    start_op(3'd3, 32'd2, 32'd3);
    wait_done(40);
    chk("post_rst_ans", 64'(ans), 64'd5);

    for (int k = 0; k < 60; k++) begin
      start_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
      wait_done(40);
    end

    repeat (5) @(negedge sw_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
